// File: rtl/fanout_skew_pkg.sv
// Shared types and default sizing for the fanout skew receiver.
package fanout_skew_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam int LANES_DEF   = 3;
   localparam int CNT_W_DEF   = 8;
   localparam int TIMEOUT_DEF = 200;

endpackage

// File: rtl/lane_edge_sync.sv
// One lane: 2-FF synchroniser plus previous-value flop; flags any level change.
module lane_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic lane_i,
   output logic level_o,
   output logic edge_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // NOTE: non-blocking assignments make all three flops sample together, giving a true shift chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= lane_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign edge_o  = sync_q ^ prev_q;

endmodule

// File: rtl/fanout_skew_rx.sv
// Measures cycle skew between the first and last lane edge of a fanout tile.
// Optional SKEW_MAX_TRACK_EN adds a sticky max_skew output.
module fanout_skew_rx
   import fanout_skew_pkg::*;
#(
   parameter int LANES   = LANES_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] lane_in,
   input  logic             arm,
   input  logic             clear,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CNT_W-1:0] skew,
   output logic [LANES-1:0] seen_mask,
   output logic             timeout,
   output logic [LANES-1:0] levels
`ifdef SKEW_MAX_TRACK_EN
   ,
   output logic [CNT_W-1:0] max_skew
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] skew_q;
   logic [LANES-1:0] seen_q;
   logic [LANES-1:0] seen_d;
   logic [LANES-1:0] levels_q;
   logic             timeout_q;
   logic [LANES-1:0] lvl_now;
   logic [LANES-1:0] edge_now;
   logic [LANES-1:0] new_edge;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_edge_sync u_sync (
         .clk     (clk),
         .rst     (rst),
         .lane_i  (lane_in[g]),
         .level_o (lvl_now[g]),
         .edge_o  (edge_now[g])
      );
   end

   assign new_edge = edge_now & ~seen_q;
   assign seen_d   = seen_q | edge_now;
   assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Edges are loaded with the post-increment count, so skew equals the cycle distance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         skew_q    <= '0;
         seen_q    <= '0;
         levels_q  <= '0;
         timeout_q <= 1'b0;
      end else if (clear) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         skew_q    <= '0;
         seen_q    <= '0;
         levels_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_q   <= ARMED;
                  seen_q    <= '0;
                  skew_q    <= '0;
                  timeout_q <= 1'b0;
               end
            end
            ARMED: begin
               if (|edge_now) begin
                  seen_q <= edge_now;
                  cnt_q  <= '0;
                  skew_q <= '0;
                  if (&edge_now) begin
                     state_q  <= DONE;
                     levels_q <= lvl_now;
                  end else begin
                     state_q <= MEASURE;
                  end
               end
            end
            MEASURE: begin
               cnt_q <= cnt_d;
               if (|new_edge) begin
                  seen_q <= seen_d;
                  skew_q <= cnt_d;
               end
               // Completion wins over timeout when both land on the same cycle.
               if (&seen_d) begin
                  state_q  <= DONE;
                  levels_q <= lvl_now;
               end else if (cnt_d >= TIMEOUT_C) begin
                  state_q   <= DONE;
                  levels_q  <= lvl_now;
                  timeout_q <= 1'b1;
               end
            end
            DONE: begin
               if (result_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = (state_q == ARMED) || (state_q == MEASURE);
   assign result_valid = (state_q == DONE);
   assign skew         = skew_q;
   assign seen_mask    = seen_q;
   assign timeout      = timeout_q;
   assign levels       = levels_q;

`ifdef SKEW_MAX_TRACK_EN
   logic             close_ok;
   logic [CNT_W-1:0] close_skew;
   logic [CNT_W-1:0] max_q;

   assign close_ok   = !clear &&
                       (((state_q == ARMED) && (&edge_now)) ||
                        ((state_q == MEASURE) && (|new_edge) && (&seen_d)));
   assign close_skew = (state_q == ARMED) ? '0 : cnt_d;

   // Deliberately untouched by clear: only rst forgets the historical maximum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_q <= '0;
      end else if (close_ok && (close_skew > max_q)) begin
         max_q <= close_skew;
      end
   end

   assign max_skew = max_q;
`endif

endmodule

// File: doc/fanout_skew_rx.md
Name: fanout_skew_rx

Overview:
Receive-side companion to our gate-level fanout/buffer-chain tiles. Those tiles launch one logic edge onto several output pins through inverter chains of different lengths. This block samples those lanes back in, synchronises them, and measures the clock-cycle skew between the first and last lane edge. It reports the result through a valid/ready handshake so a host-side readout can consume it.

Parameters:
LANES, 3, number of monitored lanes (1..8)
CNT_W, 8, width of skew counter and skew result
TIMEOUT, 200, cycles after first edge before a capture is closed incomplete (must be < 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
lane_in  input  LANES  raw lane pins, asynchronous to clk
arm  input  1  start a capture (sampled only in IDLE)
clear  input  1  synchronous abort to IDLE from any state, discards result
busy  output  1  high in ARMED or MEASURE
result_valid  output  1  capture result available
result_ready  input  1  consumer accepts result
skew  output  CNT_W  cycles from first to last lane edge
seen_mask  output  LANES  lanes that produced an edge during the capture
timeout  output  1  capture closed by TIMEOUT before all lanes seen
levels  output  LANES  synchronised lane levels at capture close

Behaviour:
- Reset: all flops, including synchronisers, clear to 0. State IDLE. Every output is 0.
- Per lane: 2-FF synchroniser plus a previous-value flop. edge = sync XOR prev, detecting both polarities. Prev updates every cycle in every state, so arming produces no false edge.
- Pin-to-detect latency is 2 cycles and identical on all lanes, so relative skew is unaffected.
- IDLE: when arm=1, go to ARMED. Clear seen_mask, skew and timeout.
- ARMED: on the first cycle with any edge, go to MEASURE.
  - Set seen_mask to the edged lanes and set the counter to 0.
  - If every lane edges in that same cycle, go directly to DONE with skew=0.
- MEASURE: counter +1 per cycle, saturating at 2^CNT_W-1. On any new edge, OR the lane into seen_mask and load skew=counter.
  - Further edges on lanes already seen are ignored.
  - When seen_mask becomes all-ones, go to DONE.
  - When counter reaches TIMEOUT with lanes missing, go to DONE with timeout=1. skew keeps the last loaded value.
  - If the final lane edges in the same cycle the counter hits TIMEOUT, the capture completes with timeout=0.
- DONE: result_valid=1 and levels is latched on entry. All result outputs hold stable until result_valid && result_ready, then go to IDLE. arm is ignored while in DONE.
- result_valid rises the cycle after the closing edge is detected.
- arm outside IDLE has no effect.
- clear in any state: go to IDLE next cycle and drop result_valid. clear has priority over arm and result_ready.
- Async rst mid-capture aborts immediately; all outputs return to 0.

Optional Feature:
SKEW_MAX_TRACK_EN
- Defined: adds output max_skew [CNT_W-1:0]. It is a sticky maximum of skew over completed, non-timeout captures, updated at DONE entry. It is cleared only by rst, not by clear.
- Undefined: the port does not exist and no max register is built.

Decomposition:
- Package fanout_skew_pkg holds:
  - state enum IDLE, ARMED, MEASURE, DONE (2-bit)
  - default constants LANES_DEF=3, CNT_W_DEF=8, TIMEOUT_DEF=200
- Sub-module lane_edge_sync: one lane's 2-FF synchroniser, previous flop, level and edge outputs. Instantiated LANES times through generate.

Test Plan:
1. Arm. Toggle lane0 at cycle t, lane1 at t+3, lane2 at t+5, with result_ready=1 -> result_valid at t+8, skew=5, seen_mask=3'b111, timeout=0, then IDLE.
2. Arm. All three lanes rise in the same cycle -> skew=0, seen_mask=3'b111, one-cycle-later valid.
3. Arm. Toggle lanes 0 and 2 only, with TIMEOUT=200 -> timeout=1, seen_mask=3'b101, skew = offset of lane2, valid 200 cycles after the first edge.
4. Complete capture with result_ready=0 for 10 cycles -> outputs stable and result_valid held; arm pulses ignored; accept on ready.
5. clear in MEASURE, and separately rst asserted mid-capture -> IDLE, result_valid=0, all outputs 0 after rst; no spurious edge on re-arm with lanes held high.
6. With SKEW_MAX_TRACK_EN: captures with skew 4, 9, 2, then one timeout -> max_skew=9.
